// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Presents registered packed BCD, a leading-zero blanking mask and a completion strobe.
module freq_bcd_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [BIN_W-1:0]      i_bin_in,
    input  logic                  i_bin_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_bcd_valid,
    output logic                  o_busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WRK_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more; digits are independent, no carry between them.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Digit i is blanked when it and every digit above it are zero; the units digit always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    state_t              r_state;
    logic [WRK_W-1:0]    r_work;      // {bcd scratch, binary shift register}
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_pend;
    logic                r_pend_vld;
    logic [BCD_W-1:0]    r_bcd;
    logic [DIGITS-1:0]   r_blank;
    logic                r_bcd_valid;
    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_scratch;

    assign w_scratch = r_work[WRK_W-1:BIN_W];
    assign w_adj     = add3_digits(w_scratch);

    // Conversion FSM with one-deep newest-wins pending buffer and registered results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_bcd       <= '0;
            r_blank     <= BLANK_RST;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_bin_valid) begin
                        r_work  <= {{BCD_W{1'b0}}, i_bin_in};
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_work <= {w_adj, r_work[BIN_W-1:0]} << 1;
                    r_cnt  <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                    if (i_bin_valid) begin
                        r_pend     <= i_bin_in;
                        r_pend_vld <= 1'b1;
                    end else begin
                        r_pend_vld <= r_pend_vld;
                    end
                end
                S_DONE: begin
                    r_bcd       <= w_scratch;
                    r_blank     <= blank_mask(w_scratch);
                    r_bcd_valid <= 1'b1;
                    // A live strobe beats the buffered sample, and discards it.
                    if (i_bin_valid) begin
                        r_work     <= {{BCD_W{1'b0}}, i_bin_in};
                        r_cnt      <= '0;
                        r_pend_vld <= 1'b0;
                        r_state    <= S_SHIFT;
                    end else if (r_pend_vld) begin
                        r_work     <= {{BCD_W{1'b0}}, r_pend};
                        r_cnt      <= '0;
                        r_pend_vld <= 1'b0;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bcd       = r_bcd;
    assign o_blank     = r_blank;
    assign o_bcd_valid = r_bcd_valid;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed table-driven bench for freq_bcd_conv plus hand-written multi-cycle sequences.
module tb_freq_bcd_conv;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_bin_in;
    logic        i_bin_valid;
    logic [19:0] o_bcd;
    logic [4:0]  o_blank;
    logic        o_bcd_valid;
    logic        o_busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    vec_t vecs[8];

    freq_bcd_conv #(.BIN_W(16), .DIGITS(5)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bin_in    (i_bin_in),
        .i_bin_valid (i_bin_valid),
        .o_bcd       (o_bcd),
        .o_blank     (o_blank),
        .o_bcd_valid (o_bcd_valid),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        i_bin_in    = v;
        i_bin_valid = 1'b1;
        step();
        i_bin_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_bcd_valid && n < 40);
    endtask

    // Strobe v0 at c=0, v1 at c1, v2 at c2; record the first two results and when busy first drops.
    task automatic run_seq(input logic [15:0] v0, input int c1, input logic [15:0] v1,
                           input int c2, input logic [15:0] v2, input int ncyc,
                           output int nv, output int cyc0, output logic [19:0] val0,
                           output int cyc1, output logic [19:0] val1, output int busy_low_at);
        nv = 0; cyc0 = -1; cyc1 = -1; val0 = '0; val1 = '0; busy_low_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            i_bin_valid = (c == 0) || (c == c1) || (c == c2);
            i_bin_in    = (c == c1) ? v1 : ((c == c2) ? v2 : v0);
            step();
            i_bin_valid = 1'b0;
            if (o_bcd_valid) begin
                if (nv == 0) begin
                    cyc0 = c; val0 = o_bcd;
                end else if (nv == 1) begin
                    cyc1 = c; val1 = o_bcd;
                end
                nv++;
            end
            if (!o_busy && busy_low_at < 0) busy_low_at = c;
        end
    endtask

    initial begin
        int n, nv, cyc0, cyc1, busy_low;
        logic [19:0] val0, val1;

        vecs[0] = '{16'd0,     20'h00000, 5'b11110};
        vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
        vecs[2] = '{16'd1000,  20'h01000, 5'b10000};
        vecs[3] = '{16'd7,     20'h00007, 5'b11110};
        vecs[4] = '{16'd10,    20'h00010, 5'b11100};
        vecs[5] = '{16'd100,   20'h00100, 5'b11000};
        vecs[6] = '{16'd59999, 20'h59999, 5'b00000};
        vecs[7] = '{16'd8080,  20'h08080, 5'b10000};

        i_rst_n     = 1'b0;
        i_bin_in    = 16'd0;
        i_bin_valid = 1'b0;
        repeat (3) step();
        chk("rst_bcd",   32'(o_bcd),       32'h0);
        chk("rst_blank", 32'(o_blank),     32'h1E);
        chk("rst_valid", 32'(o_bcd_valid), 32'h0);
        chk("rst_busy",  32'(o_busy),      32'h0);
        i_rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].bin);
            chk("busy_start", 32'(o_busy), 32'h1);
            wait_valid(n);
            chk("latency",    32'(n),         32'd17);
            chk("bcd",        32'(o_bcd),     32'(vecs[i].bcd));
            chk("blank",      32'(o_blank),   32'(vecs[i].blank));
            chk("busy_done",  32'(o_busy),    32'h0);
            step();
            chk("valid_pulse", 32'(o_bcd_valid), 32'h0);
            repeat (4) step();
            chk("bcd_hold",   32'(o_bcd),     32'(vecs[i].bcd));
            chk("blank_hold", 32'(o_blank),   32'(vecs[i].blank));
        end

        run_seq(16'd123, 5, 16'd4567, 9, 16'd89, 45, nv, cyc0, val0, cyc1, val1, busy_low);
        chk("ovl_count", 32'(nv),    32'd2);
        chk("ovl_cyc0",  32'(cyc0),  32'd17);
        chk("ovl_val0",  32'(val0),  32'h00123);
        chk("ovl_cyc1",  32'(cyc1),  32'd34);
        chk("ovl_val1",  32'(val1),  32'h00089);
        chk("ovl_busy",  32'(busy_low), 32'd34);
        repeat (3) step();

        run_seq(16'd5, 3, 16'd300, 17, 16'd42, 70, nv, cyc0, val0, cyc1, val1, busy_low);
        chk("done_count", 32'(nv),    32'd2);
        chk("done_cyc0",  32'(cyc0),  32'd17);
        chk("done_val0",  32'(val0),  32'h00005);
        chk("done_cyc1",  32'(cyc1),  32'd34);
        chk("done_val1",  32'(val1),  32'h00042);
        chk("done_busy",  32'(busy_low), 32'd34);
        chk("done_blank", 32'(o_blank), 32'h1C);

        send(16'd999);
        repeat (7) step();
        i_rst_n = 1'b0;
        #1;
        chk("abort_bcd",   32'(o_bcd),       32'h0);
        chk("abort_blank", 32'(o_blank),     32'h1E);
        chk("abort_valid", 32'(o_bcd_valid), 32'h0);
        chk("abort_busy",  32'(o_busy),      32'h0);
        repeat (2) step();
        i_rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (o_bcd_valid) nv++;
        end
        chk("abort_novalid", 32'(nv), 32'd0);
        chk("abort_idle",    32'(o_busy), 32'h0);
        send(16'd999);
        wait_valid(n);
        chk("fresh_latency", 32'(n),       32'd17);
        chk("fresh_bcd",     32'(o_bcd),   32'h00999);
        chk("fresh_blank",   32'(o_blank), 32'h18);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
